// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  localparam int DEFAULT_M  = 4;
  localparam int DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  // Index width able to address M+1 taps; never narrower than one bit.
  function automatic int ptr_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Full-width products plus headroom for summing M+1 of them.
  function automatic int acc_width(input int dw, input int m);
    return 2 * dw + ptr_width(m);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// (M+1)-entry circular sample buffer: one write port, whole-buffer clear, one indexed read.
module fir_delay_line #(
  parameter int M  = 4,
  parameter int DW = 32,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] dl_reg [M+1];
  logic [M:0]    wr_hit;

  genvar gi;
  for (gi = 0; gi <= M; gi++) begin : g_hit
    assign wr_hit[gi] = wr_en && (wr_addr == PW'(gi));
  end

  // Registers rather than RAM: the clear must zero every entry in one cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= M; i++) begin
      if (!rst_ || clr) begin
        dl_reg[i] <= '0;
      end else if (wr_hit[i]) begin
        dl_reg[i] <= wr_data;
      end
    end
  end

  assign rd_data = (rd_addr <= PW'(M)) ? dl_reg[rd_addr] : '0;

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR filter sharing one multiplier/accumulator across M+1 taps per sample.
// Define FIR_SEQ_SAT_EN to saturate dout to the signed DW range instead of wrapping.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int M  = DEFAULT_M,
  parameter int DW = DEFAULT_DW
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [M:0][DW-1:0]   coeffs,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic signed [DW-1:0] din,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic signed [DW-1:0] dout,
  input  logic                 flush,
  output logic                 busy
);

  localparam int AW = acc_width(DW, M);
  localparam int PW = ptr_width(M);
  localparam logic [PW-1:0] LAST = PW'(M);

  fir_state_e              state_reg, state_next;
  logic [PW-1:0]           k_reg, k_next;
  logic [PW-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]           rd_addr;
  logic [M:0][DW-1:0]      coeff_snap_reg, coeff_snap_next;
  logic signed [AW-1:0]    acc_reg, acc_next;
  logic [DW-1:0]           tap_data;
  logic signed [2*DW-1:0]  coef_ext, tap_ext, prod;
  logic signed [AW-1:0]    prod_ext;
  logic                    accept, dl_clr;

  assign accept = (state_reg == IDLE) && din_valid && !flush;
  assign dl_clr = (state_reg == IDLE) && flush;

  // x[n-k] sits k slots behind the newest write, modulo M+1.
  assign rd_addr = (wr_ptr_reg >= k_reg) ? (wr_ptr_reg - k_reg)
                                         : (wr_ptr_reg + PW'(M + 1) - k_reg);

  fir_delay_line #(
    .M  (M),
    .DW (DW),
    .PW (PW)
  ) u_delay_line (
    .clk     (clk),
    .rst_    (rst_),
    .clr     (dl_clr),
    .wr_en   (accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (din),
    .rd_addr (rd_addr),
    .rd_data (tap_data)
  );

  assign coef_ext = {{DW{coeff_snap_reg[k_reg][DW-1]}}, coeff_snap_reg[k_reg]};
  assign tap_ext  = {{DW{tap_data[DW-1]}}, tap_data};
  assign prod     = coef_ext * tap_ext;
  assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};

  always_comb begin
    state_next      = state_reg;
    k_next          = k_reg;
    wr_ptr_next     = wr_ptr_reg;
    coeff_snap_next = coeff_snap_reg;
    acc_next        = acc_reg;
    unique case (state_reg)
      IDLE: begin
        if (flush) begin
          wr_ptr_next = '0;
        end else if (din_valid) begin
          coeff_snap_next = coeffs;
          acc_next        = '0;
          k_next          = '0;
          state_next      = MAC;
        end
      end
      MAC: begin
        acc_next = acc_reg + prod_ext;
        if (k_reg == LAST) begin
          k_next     = '0;
          state_next = OUT;
        end else begin
          k_next = k_reg + PW'(1);
        end
      end
      OUT: begin
        if (dout_ready) begin
          wr_ptr_next = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + PW'(1);
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      wr_ptr_reg     <= '0;
      coeff_snap_reg <= '0;
      acc_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      wr_ptr_reg     <= wr_ptr_next;
      coeff_snap_reg <= coeff_snap_next;
      acc_reg        <= acc_next;
    end
  end

  assign din_ready  = (state_reg == IDLE) && !flush;
  assign dout_valid = (state_reg == OUT);
  assign busy       = (state_reg != IDLE);

`ifdef FIR_SEQ_SAT_EN
  // In range exactly when every bit above the DW-1 sign bit matches it.
  always_comb begin
    if (acc_reg[AW-1:DW-1] == {(AW-DW+1){acc_reg[AW-1]}}) begin
      dout = acc_reg[DW-1:0];
    end else if (acc_reg[AW-1]) begin
      dout = {1'b1, {(DW-1){1'b0}}};
    end else begin
      dout = {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign dout = acc_reg[DW-1:0];
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (M=4, DW=32) with hand-computed expected outputs.
module tb_fir_mac_sequencer;

  logic              clk = 1'b0;
  logic              rst_;
  logic [4:0][31:0]  coeffs;
  logic              din_valid, din_ready;
  logic signed [31:0] din;
  logic              dout_valid, dout_ready;
  logic signed [31:0] dout;
  logic              flush, busy;

  int cyc_cnt  = 0;
  int last_acc = 0;
  int n_vec    = 0;
  int n_err    = 0;

`ifdef FIR_SEQ_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFB;
`endif

  fir_mac_sequencer #(.M(4), .DW(32)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .coeffs     (coeffs),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .flush      (flush),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coeffs(input int c0, input int c1, input int c2, input int c3, input int c4);
    coeffs[0] = c0;
    coeffs[1] = c1;
    coeffs[2] = c2;
    coeffs[3] = c3;
    coeffs[4] = c4;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // One sample through the pipe with dout_ready high; ends just after the output handshake.
  task automatic run_sample(input string tag, input logic [31:0] x, input logic [31:0] exp,
                            input bit chk_gap, input bit zero_coef);
    int cyc;
    cyc = 0;
    while (!din_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check_vec({tag, "_rdy"}, din_ready, 1);
    din       = x;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = 32'hDEAD_BEEF;
    if (chk_gap) check_vec({tag, "_gap"}, cyc_cnt - last_acc, 7);
    last_acc = cyc_cnt;
    cyc = 0;
    while (!dout_valid && cyc < 20) begin
      tick();
      cyc++;
      if (zero_coef && cyc == 1) coeffs = '0;
    end
    $display("xfer %-8s din=%08h dout=%08h lat=%0d", tag, x, dout, cyc);
    check_vec({tag, "_lat"}, cyc, 5);
    check_vec({tag, "_dout"}, dout, exp);
    tick();
  endtask

  task automatic run_impulse(input string tag);
    int e[5] = '{-1, 2, 5, 2, -1};
    for (int i = 0; i < 5; i++) begin
      run_sample($sformatf("%s%0d", tag, i), (i == 0) ? 32'd1 : 32'd0, e[i], 1'b0, 1'b0);
    end
  endtask

  initial begin
    int cyc;
    int vcount;
    int imp_exp[7]  = '{-1, 2, 5, 2, -1, 0, 0};
    int step_exp[6] = '{-1, 1, 6, 8, 7, 7};

    rst_       = 1'b0;
    din_valid  = 1'b0;
    din        = '0;
    dout_ready = 1'b1;
    flush      = 1'b0;
    set_coeffs(-1, 2, 5, 2, -1);
    repeat (3) tick();
    check_vec("rst_busy", busy, 0);
    check_vec("rst_vld", dout_valid, 0);
    check_vec("rst_dout", dout, 0);
    rst_ = 1'b1;
    tick();
    check_vec("rst_rdy", din_ready, 1);

    for (int i = 0; i < 7; i++)
      run_sample($sformatf("imp%0d", i), (i == 0) ? 32'd1 : 32'd0, imp_exp[i], 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      run_sample($sformatf("step%0d", i), 32'd1, step_exp[i], i > 0, 1'b0);

    // Abort a sample at k=2 with step residue in the delay line.
    din       = 32'd7;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    check_vec("abrt_busy1", busy, 1);
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    check_vec("abrt_busy0", busy, 0);
    vcount = 0;
    repeat (10) begin
      if (dout_valid) vcount++;
      tick();
    end
    check_vec("abrt_novld", vcount, 0);
    run_impulse("abimp");

    for (int i = 0; i < 5; i++)
      run_sample($sformatf("stp2_%0d", i), 32'd1, step_exp[i], 1'b0, 1'b0);

    // Flush together with a valid sample: flush wins, nothing accepted.
    flush     = 1'b1;
    din_valid = 1'b1;
    din       = 32'd1;
    #1;
    check_vec("fl_rdy", din_ready, 0);
    tick();
    check_vec("fl_busy", busy, 0);
    flush     = 1'b0;
    din_valid = 1'b0;
    run_impulse("flimp");

    // Backpressure: hold the result for six cycles.
    dout_ready = 1'b0;
    din        = 32'd3;
    din_valid  = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = 32'h5555_5555;
    cyc = 0;
    while (!dout_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check_vec("bp_lat", cyc, 5);
    for (int i = 0; i < 6; i++) begin
      check_vec($sformatf("bp_dout%0d", i), dout, -32'sd3);
      check_vec($sformatf("bp_rdy%0d", i), din_ready, 0);
      check_vec($sformatf("bp_busy%0d", i), busy, 1);
      tick();
    end
    $display("xfer %-8s din=%08h dout=%08h lat=%0d", "bp", 32'd3, dout, cyc);
    dout_ready = 1'b1;
    tick();
    check_vec("bp_rel_vld", dout_valid, 0);
    check_vec("bp_rel_busy", busy, 0);
    run_sample("bp_next", 32'd0, 32'd6, 1'b0, 1'b0);

    // Coefficients zeroed one cycle after accept must not touch the sample in flight.
    do_flush();
    run_sample("coef0", 32'd1, -32'sd1, 1'b0, 1'b1);
    run_sample("coef1", 32'd1, 32'd0, 1'b0, 1'b0);

    set_coeffs(5, 0, 0, 0, 0);
    do_flush();
    run_sample("sat", 32'h7FFF_FFFF, SAT_EXP, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
